// File: rtl/uart_cmd_parser_if.sv
// Byte-in / register-request-out bundle for the ASCII hex command parser.
// The slave modport is the parser side; the master modport is the byte source and request consumer.
interface uart_cmd_parser_if #(
  parameter int unsigned ADDR_NIBBLES = 2,
  parameter int unsigned DATA_NIBBLES = 2
);
  logic                        Done_i;
  logic [7:0]                  Data_i;
  logic                        WriteStrobe_o;
  logic                        ReadStrobe_o;
  logic [4*ADDR_NIBBLES-1:0]   Address_o;
  logic [4*DATA_NIBBLES-1:0]   WriteData_o;
  logic                        Error_o;
  logic [1:0]                  ErrorCode_o;
  logic                        Busy_o;

  modport slave (
    input  Done_i, Data_i,
    output WriteStrobe_o, ReadStrobe_o, Address_o, WriteData_o, Error_o, ErrorCode_o, Busy_o
  );

  modport master (
    output Done_i, Data_i,
    input  WriteStrobe_o, ReadStrobe_o, Address_o, WriteData_o, Error_o, ErrorCode_o, Busy_o
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Parses 'W'<addr><data><CR|LF> and 'R'<addr><CR|LF> ASCII hex frames from the UART receiver
// into one-cycle register-bus write/read strobes, with error reporting and inter-byte timeout.
module uart_cmd_parser #(
  parameter int unsigned ADDR_NIBBLES  = 2,
  parameter int unsigned DATA_NIBBLES  = 2,
  parameter int unsigned TIMEOUT_TICKS = 100_000
) (
  input logic               Clock,
  input logic               Reset,
  uart_cmd_parser_if.slave  bus
);

  localparam int unsigned AW     = 4 * ADDR_NIBBLES;
  localparam int unsigned DW     = 4 * DATA_NIBBLES;
  localparam int unsigned MaxNib = (ADDR_NIBBLES > DATA_NIBBLES) ? ADDR_NIBBLES : DATA_NIBBLES;
  localparam int unsigned DigW   = $clog2(MaxNib + 1);
  localparam int unsigned TW     = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS);

  localparam bit               TimeoutEn = (TIMEOUT_TICKS != 0);
  localparam logic [TW-1:0]    TickLast  = TW'(TIMEOUT_TICKS - 1);
  localparam logic [DigW-1:0]  AddrLast  = DigW'(ADDR_NIBBLES - 1);
  localparam logic [DigW-1:0]  DataLast  = DigW'(DATA_NIBBLES - 1);

  localparam logic [1:0] ErrBadChar = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;
  localparam logic [1:0] ErrShort   = 2'b11;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StEnd} state_e;

  state_e          state_q, state_d;
  logic            is_write_q, is_write_d;
  logic [AW-1:0]   addr_sh_q, addr_sh_d;
  logic [DW-1:0]   data_sh_q, data_sh_d;
  logic [DigW-1:0] digit_q, digit_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic            wr_q, wr_d, rd_q, rd_d, err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic [AW-1:0]   addr_out_q, addr_out_d;
  logic [DW-1:0]   wdata_out_q, wdata_out_d;

  logic       is_hex, is_term, is_space, timeout;
  logic [3:0] nibble;

  // Byte classification: hex digit value, frame terminator, ignorable whitespace.
  always_comb begin
    is_hex = 1'b1;
    nibble = 4'h0;
    if (bus.Data_i >= 8'h30 && bus.Data_i <= 8'h39) begin
      nibble = 4'(bus.Data_i - 8'h30);
    end else if (bus.Data_i >= 8'h41 && bus.Data_i <= 8'h46) begin
      nibble = 4'(bus.Data_i - 8'h37);
    end else if (bus.Data_i >= 8'h61 && bus.Data_i <= 8'h66) begin
      nibble = 4'(bus.Data_i - 8'h57);
    end else begin
      is_hex = 1'b0;
    end
    is_term  = (bus.Data_i == 8'h0D) || (bus.Data_i == 8'h0A);
    is_space = (bus.Data_i == 8'h20);
  end

  // A byte arriving on the expiry cycle suppresses the timeout.
  assign timeout = TimeoutEn && (state_q != StIdle) && !bus.Done_i && (tick_q == TickLast);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= StIdle;
      is_write_q  <= 1'b0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      digit_q     <= '0;
      tick_q      <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 2'b00;
      addr_out_q  <= '0;
      wdata_out_q <= '0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      digit_q     <= digit_d;
      tick_q      <= tick_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      code_q      <= code_d;
      addr_out_q  <= addr_out_d;
      wdata_out_q <= wdata_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    digit_d     = digit_q;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    err_d       = 1'b0;
    code_d      = code_q;
    addr_out_d  = addr_out_q;
    wdata_out_d = wdata_out_q;
    tick_d      = (bus.Done_i || state_q == StIdle) ? '0 : tick_q + TW'(1);

    if (timeout) begin
      err_d   = 1'b1;
      code_d  = ErrTimeout;
      state_d = StIdle;
    end else if (bus.Done_i) begin
      unique case (state_q)
        StIdle: begin
          if (bus.Data_i == 8'h57 || bus.Data_i == 8'h77) begin
            is_write_d = 1'b1;
            digit_d    = '0;
            state_d    = StAddr;
          end else if (bus.Data_i == 8'h52 || bus.Data_i == 8'h72) begin
            is_write_d = 1'b0;
            digit_d    = '0;
            state_d    = StAddr;
          end else if (!(is_term || is_space)) begin
            err_d  = 1'b1;
            code_d = ErrBadChar;
          end
        end
        StAddr: begin
          if (is_hex) begin
            addr_sh_d = (addr_sh_q << 4) | AW'(nibble);
            if (digit_q == AddrLast) begin
              digit_d = '0;
              state_d = is_write_q ? StData : StEnd;
            end else begin
              digit_d = digit_q + DigW'(1);
            end
          end else begin
            err_d   = 1'b1;
            code_d  = is_term ? ErrShort : ErrBadChar;
            state_d = StIdle;
          end
        end
        StData: begin
          if (is_hex) begin
            data_sh_d = (data_sh_q << 4) | DW'(nibble);
            if (digit_q == DataLast) begin
              digit_d = '0;
              state_d = StEnd;
            end else begin
              digit_d = digit_q + DigW'(1);
            end
          end else begin
            err_d   = 1'b1;
            code_d  = is_term ? ErrShort : ErrBadChar;
            state_d = StIdle;
          end
        end
        StEnd: begin
          if (is_term) begin
            addr_out_d = addr_sh_q;
            if (is_write_q) begin
              wr_d        = 1'b1;
              wdata_out_d = data_sh_q;
            end else begin
              rd_d = 1'b1;
            end
          end else begin
            err_d  = 1'b1;
            code_d = ErrBadChar;
          end
          state_d = StIdle;
        end
      endcase
    end

    if (state_d == StIdle) tick_d = '0;
  end

  always_comb begin
    bus.WriteStrobe_o = wr_q;
    bus.ReadStrobe_o  = rd_q;
    bus.Error_o       = err_q;
    bus.ErrorCode_o   = code_q;
    bus.Address_o     = addr_out_q;
    bus.WriteData_o   = wdata_out_q;
    bus.Busy_o        = (state_q != StIdle);
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench: directed frame table, hand-written timeout/reset sequences and random
// byte streams, all compared cycle-by-cycle against a frame-level reference model.
module tb_uart_cmd_parser;
  localparam int unsigned AN = 2;
  localparam int unsigned DN = 2;
  localparam int unsigned TO = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_parser_if #(.ADDR_NIBBLES(AN), .DATA_NIBBLES(DN)) bus ();

  uart_cmd_parser #(
    .ADDR_NIBBLES (AN),
    .DATA_NIBBLES (DN),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .Clock(clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the frame is held as the list of bytes received so far.
  byte unsigned frame[$];
  int           idle_cnt;
  logic [7:0]   m_addr, m_wdata;
  logic [1:0]   m_code;
  bit           m_wr, m_rd, m_err;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_hex(byte unsigned c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic int hexval(byte unsigned c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return int'(c) - 87;
  endfunction

  task automatic raise(logic [1:0] code);
    m_err  = 1'b1;
    m_code = code;
    frame.delete();
  endtask

  task automatic model_byte(byte unsigned c);
    bit term;
    bit wr;
    int need;
    int have;
    int a;
    int d;
    term = (c == 8'h0D) || (c == 8'h0A);
    if (frame.size() == 0) begin
      if (c == "W" || c == "w" || c == "R" || c == "r") frame.push_back(c);
      else if (!(term || c == " ")) raise(2'b01);
    end else begin
      wr   = (frame[0] == "W") || (frame[0] == "w");
      need = int'(AN) + (wr ? int'(DN) : 0);
      have = frame.size() - 1;
      if (have < need) begin
        if (is_hex(c)) frame.push_back(c);
        else raise(term ? 2'b11 : 2'b01);
      end else if (term) begin
        a = 0;
        d = 0;
        for (int i = 1; i <= int'(AN); i++) a = a * 16 + hexval(frame[i]);
        m_addr = 8'(a);
        if (wr) begin
          for (int i = int'(AN) + 1; i <= need; i++) d = d * 16 + hexval(frame[i]);
          m_wdata = 8'(d);
          m_wr    = 1'b1;
        end else begin
          m_rd = 1'b1;
        end
        frame.delete();
      end else begin
        raise(2'b01);
      end
    end
  endtask

  task automatic model_step(bit r, bit d, byte unsigned c);
    m_wr  = 1'b0;
    m_rd  = 1'b0;
    m_err = 1'b0;
    if (!r) begin
      frame.delete();
      idle_cnt = 0;
      m_addr   = '0;
      m_wdata  = '0;
      m_code   = '0;
    end else if (d) begin
      idle_cnt = 0;
      model_byte(c);
    end else if (frame.size() != 0) begin
      idle_cnt++;
      if (idle_cnt == int'(TO)) begin
        raise(2'b10);
        idle_cnt = 0;
      end
    end
  endtask

  // One clock: drive inputs, step the model with what the DUT samples, compare after the edge.
  task automatic cycle(bit d, byte unsigned c);
    bus.Done_i = d;
    bus.Data_i = c;
    @(posedge clk);
    model_step(rst_n, d, c);
    #1;
    check("wr_strobe", bus.WriteStrobe_o, m_wr);
    check("rd_strobe", bus.ReadStrobe_o, m_rd);
    check("error", bus.Error_o, m_err);
    check("error_code", bus.ErrorCode_o, m_code);
    check("address", bus.Address_o, m_addr);
    check("write_data", bus.WriteData_o, m_wdata);
    check("busy", bus.Busy_o, frame.size() != 0);
    bus.Done_i = 1'b0;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i]);
  endtask

  task automatic idle(int n);
    repeat (n) cycle(1'b0, 8'h00);
  endtask

  typedef struct {
    string      s;
    bit         wr;
    bit         rd;
    bit         err;
    logic [1:0] code;
    logic [7:0] addr;
    logic [7:0] wdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    string pool;
    byte unsigned b;
    int gap;

    pool = "0123456789abcdefABCDEFWwRrGgz \r\n";
    vecs[0] = '{"W1Aff\r",    1, 0, 0, 2'b00, 8'h1A, 8'hFF};
    vecs[1] = '{"r3C\n",      0, 1, 0, 2'b00, 8'h3C, 8'hFF};
    vecs[2] = '{"W1G",        0, 0, 1, 2'b01, 8'h3C, 8'hFF};
    vecs[3] = '{"R05\r",      0, 1, 0, 2'b01, 8'h05, 8'hFF};
    vecs[4] = '{"W12\r",      0, 0, 1, 2'b11, 8'h05, 8'hFF};
    vecs[5] = '{" \n\rw0a5B\r", 1, 0, 0, 2'b11, 8'h0A, 8'h5B};
    vecs[6] = '{"RA\r",       0, 0, 1, 2'b11, 8'h0A, 8'h5B};
    vecs[7] = '{"W12345",     0, 0, 1, 2'b01, 8'h0A, 8'h5B};
    vecs[8] = '{"Q",          0, 0, 1, 2'b01, 8'h0A, 8'h5B};
    vecs[9] = '{"R\r",        0, 0, 1, 2'b11, 8'h0A, 8'h5B};

    bus.Done_i = 1'b0;
    bus.Data_i = 8'h00;
    frame.delete();
    idle_cnt = 0;
    m_addr = '0; m_wdata = '0; m_code = '0;

    // Reset with Done_i active: the byte must be ignored.
    rst_n = 1'b0;
    cycle(1'b1, "W");
    cycle(1'b1, "R");
    check("reset busy", bus.Busy_o, 1'b0);
    check("reset address", bus.Address_o, 8'h00);
    rst_n = 1'b1;
    idle(2);

    foreach (vecs[i]) begin
      send_str(vecs[i].s);
      check($sformatf("vec%0d wr", i), bus.WriteStrobe_o, vecs[i].wr);
      check($sformatf("vec%0d rd", i), bus.ReadStrobe_o, vecs[i].rd);
      check($sformatf("vec%0d err", i), bus.Error_o, vecs[i].err);
      check($sformatf("vec%0d code", i), bus.ErrorCode_o, vecs[i].code);
      check($sformatf("vec%0d addr", i), bus.Address_o, vecs[i].addr);
      check($sformatf("vec%0d wdata", i), bus.WriteData_o, vecs[i].wdata);
      check($sformatf("vec%0d busy", i), bus.Busy_o, 1'b0);
      idle(1);
      check($sformatf("vec%0d pulse width", i),
            {bus.WriteStrobe_o, bus.ReadStrobe_o, bus.Error_o}, 3'b000);
    end

    // Timeout: 50 quiet cycles after the last byte.
    send_str("W1");
    idle(TO - 1);
    check("timeout not yet", bus.Error_o, 1'b0);
    check("timeout busy before", bus.Busy_o, 1'b1);
    idle(1);
    check("timeout error", bus.Error_o, 1'b1);
    check("timeout code", bus.ErrorCode_o, 2'b10);
    check("timeout busy after", bus.Busy_o, 1'b0);

    // Byte arriving on the expiry cycle wins.
    send_str("W1");
    idle(TO - 1);
    cycle(1'b1, "A");
    check("expiry byte no error", bus.Error_o, 1'b0);
    check("expiry byte busy", bus.Busy_o, 1'b1);
    send_str("ff\r");
    check("expiry frame wr", bus.WriteStrobe_o, 1'b1);
    check("expiry frame addr", bus.Address_o, 8'h1A);
    check("expiry frame wdata", bus.WriteData_o, 8'hFF);

    // Reset mid-frame discards the partial frame silently.
    send_str("W12");
    rst_n = 1'b0;
    cycle(1'b1, "5");
    rst_n = 1'b1;
    check("midreset wr", bus.WriteStrobe_o, 1'b0);
    check("midreset err", bus.Error_o, 1'b0);
    check("midreset code", bus.ErrorCode_o, 2'b00);
    check("midreset addr", bus.Address_o, 8'h00);
    check("midreset wdata", bus.WriteData_o, 8'h00);
    check("midreset busy", bus.Busy_o, 1'b0);
    send_str("3");
    check("post-reset digit err", bus.Error_o, 1'b1);
    check("post-reset digit code", bus.ErrorCode_o, 2'b01);
    cycle(1'b1, 8'h0D);
    check("post-reset CR ignored", bus.Error_o, 1'b0);
    check("post-reset CR idle", bus.Busy_o, 1'b0);

    // Random frames with corruption, gaps, expiry-cycle bytes, timeouts and resets.
    for (int n = 0; n < 400; n++) begin
      int len;
      byte unsigned fr[$];
      fr.delete();
      case ($urandom_range(0, 3))
        0: fr.push_back("W");
        1: fr.push_back("w");
        2: fr.push_back("R");
        default: fr.push_back("r");
      endcase
      len = ((fr[0] == "W") || (fr[0] == "w")) ? int'(AN + DN) : int'(AN);
      for (int i = 0; i < len; i++) fr.push_back(pool[$urandom_range(0, 21)]);
      fr.push_back(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
      if ($urandom_range(0, 3) == 0) begin
        int pos;
        pos = $urandom_range(0, fr.size() - 1);
        if ($urandom_range(0, 4) == 0) fr[pos] = 8'($urandom);
        else fr[pos] = pool[$urandom_range(0, pool.len() - 1)];
      end
      if ($urandom_range(0, 9) == 0) fr.push_back(pool[$urandom_range(0, pool.len() - 1)]);
      foreach (fr[i]) begin
        gap = $urandom_range(0, 99);
        if (gap < 2) idle(TO - 1);
        else if (gap < 4) idle(TO + $urandom_range(0, 2));
        else if (gap < 5) begin
          rst_n = 1'b0;
          cycle($urandom_range(0, 1) != 0, fr[i]);
          rst_n = 1'b1;
        end else if (gap < 25) idle($urandom_range(1, 3));
        b = fr[i];
        cycle(1'b1, b);
      end
      idle($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
